// File: rtl/uart_rx_fifo_if.sv
// Bus of uart_rx_fifo: serial line and FIFO pop in, FIFO head and status pulses out.
interface uart_rx_fifo_if;
    logic       rx_i;
    logic       rd_en_i;
    logic [7:0] data_o;
    logic       fifo_empty_o;
    logic       fifo_full_o;
    logic       frame_error_o;
    logic       overrun_o;

    modport master (
        output rx_i, rd_en_i,
        input  data_o, fifo_empty_o, fifo_full_o, frame_error_o, overrun_o
    );
    modport slave (
        input  rx_i, rd_en_i,
        output data_o, fifo_empty_o, fifo_full_o, frame_error_o, overrun_o
    );
endinterface

// File: rtl/uart_rx_fifo.sv
// 8N1 UART receiver with oversampled mid-bit sampling feeding a first-word-fall-through FIFO.
// Framing errors and overruns are reported as single-cycle pulses.
module uart_rx_fifo #(
    parameter real CLK_FREQ       = 20e6,
    parameter real BAUD           = 115.2e3,
    parameter int  OVERSAMPLE     = 16,
    parameter int  FIFO_ADDR_BITS = 3
) (
    input  logic          clk,
    input  logic          rst,
    uart_rx_fifo_if.slave bus
);
    localparam int          DIV_R = int'(CLK_FREQ / (BAUD * real'(OVERSAMPLE)));
    localparam int unsigned DIV   = (DIV_R < 1) ? 1 : DIV_R;
    localparam int unsigned DIV_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int unsigned SC_W  = $clog2(OVERSAMPLE);
    localparam int unsigned AW    = FIFO_ADDR_BITS;
    localparam int unsigned CW    = FIFO_ADDR_BITS + 1;
    localparam int unsigned DEPTH = 2 ** FIFO_ADDR_BITS;
    localparam logic [SC_W-1:0] SC_HALF = SC_W'(OVERSAMPLE / 2 - 1);
    localparam logic [SC_W-1:0] SC_LAST = SC_W'(OVERSAMPLE - 1);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    logic             sync1_q, rx_s, rx_p;
    logic [DIV_W-1:0] div_cnt_q;
    logic             tick_c, start_c;
    state_t           state_q, state_d;
    logic [SC_W-1:0]  sc_q, sc_d;
    logic [3:0]       bc_q, bc_d;
    logic [7:0]       shreg_q, shreg_d;
    logic             push_c, ferr_c, ovr_c, pop_c;

    logic [7:0]       mem [DEPTH];
    logic [AW-1:0]    wr_ptr_q, rd_ptr_q, rd_nxt_c;
    logic [CW-1:0]    count_q, count_d;
    logic [7:0]       data_q, head_c;
    logic             empty_q, full_q, ferr_q, ovr_q;

    // Two-flop synchronizer plus one delayed copy for falling-edge detection
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q <= 1'b1;
            rx_s    <= 1'b1;
            rx_p    <= 1'b1;
        end else begin
            sync1_q <= bus.rx_i;
            rx_s    <= sync1_q;
            rx_p    <= rx_s;
        end
    end

    // Oversample tick; restarted on start detection so the phase follows the line
    assign tick_c = (div_cnt_q == DIV_W'(DIV - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst)                   div_cnt_q <= '0;
        else if (start_c || tick_c) div_cnt_q <= '0;
        else                       div_cnt_q <= div_cnt_q + DIV_W'(1);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            sc_q    <= '0;
            bc_q    <= '0;
            shreg_q <= '0;
        end else begin
            state_q <= state_d;
            sc_q    <= sc_d;
            bc_q    <= bc_d;
            shreg_q <= shreg_d;
        end
    end

    always_comb begin
        state_d = state_q;
        sc_d    = sc_q;
        bc_d    = bc_q;
        shreg_d = shreg_q;
        start_c = 1'b0;
        push_c  = 1'b0;
        ferr_c  = 1'b0;
        ovr_c   = 1'b0;
        unique case (state_q)
            IDLE: begin
                // Requires a high-to-low transition, so a held break never re-triggers
                if (rx_p && !rx_s) begin
                    start_c = 1'b1;
                    state_d = START;
                    sc_d    = '0;
                end
            end
            START: begin
                if (tick_c) begin
                    if (sc_q == SC_HALF) begin
                        if (!rx_s) begin
                            state_d = DATA;
                            sc_d    = '0;
                            bc_d    = '0;
                        end else begin
                            state_d = IDLE;
                        end
                    end else begin
                        sc_d = sc_q + SC_W'(1);
                    end
                end
            end
            DATA: begin
                if (tick_c) begin
                    if (sc_q == SC_LAST) begin
                        shreg_d = {rx_s, shreg_q[7:1]};
                        sc_d    = '0;
                        bc_d    = bc_q + 4'd1;
                        if (bc_q == 4'd7) state_d = STOP;
                    end else begin
                        sc_d = sc_q + SC_W'(1);
                    end
                end
            end
            STOP: begin
                if (tick_c) begin
                    if (sc_q == SC_LAST) begin
                        state_d = IDLE;
                        if (!rx_s)                          ferr_c = 1'b1;
                        else if (!full_q || bus.rd_en_i)   push_c = 1'b1;
                        else                               ovr_c  = 1'b1;
                    end else begin
                        sc_d = sc_q + SC_W'(1);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // FIFO bookkeeping; the head register is preloaded so data_o is valid the cycle after a push/pop
    assign pop_c    = bus.rd_en_i && !empty_q;
    assign rd_nxt_c = pop_c ? rd_ptr_q + AW'(1) : rd_ptr_q;
    assign head_c   = (push_c && (wr_ptr_q == rd_nxt_c)) ? shreg_q : mem[rd_nxt_c];

    always_comb begin
        count_d = count_q;
        if (push_c && !pop_c)      count_d = count_q + CW'(1);
        else if (!push_c && pop_c) count_d = count_q - CW'(1);
    end

    always_ff @(posedge clk) begin
        if (push_c) mem[wr_ptr_q] <= shreg_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            data_q   <= '0;
            empty_q  <= 1'b1;
            full_q   <= 1'b0;
            ferr_q   <= 1'b0;
            ovr_q    <= 1'b0;
        end else begin
            if (push_c) wr_ptr_q <= wr_ptr_q + AW'(1);
            rd_ptr_q <= rd_nxt_c;
            count_q  <= count_d;
            data_q   <= head_c;
            empty_q  <= (count_d == '0);
            full_q   <= (count_d == CW'(DEPTH));
            ferr_q   <= ferr_c;
            ovr_q    <= ovr_c;
        end
    end

    assign bus.data_o        = data_q;
    assign bus.fifo_empty_o  = empty_q;
    assign bus.fifo_full_o   = full_q;
    assign bus.frame_error_o = ferr_q;
    assign bus.overrun_o     = ovr_q;
endmodule

// File: tb/tb_uart_rx_fifo.sv
// Self-checking bench for uart_rx_fifo: table of frames plus hand-written corner sequences,
// with a byte scoreboard filled when frames are sent and drained when the FIFO is popped.
module tb_uart_rx_fifo;
    localparam int BIT_T = 160;  // 16 clk per bit at a 10-unit clock

    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;
    int   ferr_cyc = 0;
    int   ovr_cyc = 0;
    logic [7:0] exp_q[$];

    typedef struct {
        logic [7:0] data;
        logic       stop;
        int         bit_t;
        logic       exp_push;
        int         exp_ferr;
    } vec_t;

    vec_t vecs[7];

    uart_rx_fifo_if u_if ();

    uart_rx_fifo #(
        .CLK_FREQ      (20e6),
        .BAUD          (1.25e6),
        .OVERSAMPLE    (16),
        .FIFO_ADDR_BITS(3)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(u_if)
    );

    always #5 clk = ~clk;

    // Pulse widths: each 1-clk pulse adds exactly one
    always @(negedge clk) begin
        if (u_if.frame_error_o === 1'b1) ferr_cyc <= ferr_cyc + 1;
        if (u_if.overrun_o === 1'b1)     ovr_cyc  <= ovr_cyc + 1;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stop, input int bit_t);
        u_if.rx_i = 1'b0;
        #(bit_t);
        for (int i = 0; i < 8; i++) begin
            u_if.rx_i = d[i];
            #(bit_t);
        end
        u_if.rx_i = stop;
        #(bit_t);
        u_if.rx_i = 1'b1;
    endtask

    task automatic pop_check(input string name);
        logic [7:0] exp;
        exp = (exp_q.size() != 0) ? exp_q.pop_front() : 8'hxx;
        check({name, "_nonempty"}, 32'(u_if.fifo_empty_o), 32'd0);
        check({name, "_data"}, 32'(u_if.data_o), 32'(exp));
        u_if.rd_en_i = 1'b1;
        tick(1);
        u_if.rd_en_i = 1'b0;
    endtask

    initial begin
        int f0, o0;
        vecs[0] = '{8'hA5, 1'b1, 160, 1'b1, 0};
        vecs[1] = '{8'h3C, 1'b0, 160, 1'b0, 1};
        vecs[2] = '{8'h81, 1'b1, 160, 1'b1, 0};
        vecs[3] = '{8'h55, 1'b1, 155, 1'b1, 0};
        vecs[4] = '{8'h55, 1'b1, 165, 1'b1, 0};
        vecs[5] = '{8'h00, 1'b1, 160, 1'b1, 0};
        vecs[6] = '{8'hFF, 1'b1, 160, 1'b1, 0};

        rst = 1'b1;
        u_if.rx_i = 1'b1;
        u_if.rd_en_i = 1'b0;
        tick(3);
        check("rst_empty", 32'(u_if.fifo_empty_o), 32'd1);
        check("rst_full", 32'(u_if.fifo_full_o), 32'd0);
        check("rst_ferr", 32'(u_if.frame_error_o), 32'd0);
        check("rst_ovr", 32'(u_if.overrun_o), 32'd0);
        rst = 1'b0;
        tick(3);

        // Exact latency: push lands on the edge 155 clk after the start bit is driven
        f0 = ferr_cyc; o0 = ovr_cyc;
        exp_q.push_back(8'hA5);
        fork
            send_frame(8'hA5, 1'b1, BIT_T);
            begin
                tick(154);
                check("lat_empty_before", 32'(u_if.fifo_empty_o), 32'd1);
                tick(1);
                check("lat_empty_after", 32'(u_if.fifo_empty_o), 32'd0);
            end
        join
        pop_check("lat_pop");
        check("lat_empty_popped", 32'(u_if.fifo_empty_o), 32'd1);
        check("lat_ferr", 32'(ferr_cyc - f0), 32'd0);
        check("lat_ovr", 32'(ovr_cyc - o0), 32'd0);

        // Short low glitch is rejected silently
        f0 = ferr_cyc;
        u_if.rx_i = 1'b0;
        tick(4);
        u_if.rx_i = 1'b1;
        tick(40);
        check("glitch_empty", 32'(u_if.fifo_empty_o), 32'd1);
        check("glitch_ferr", 32'(ferr_cyc - f0), 32'd0);

        // Table of frames, including bad stop and +/-3% bit-period mismatch
        for (int i = 0; i < 7; i++) begin
            f0 = ferr_cyc; o0 = ovr_cyc;
            if (vecs[i].exp_push) exp_q.push_back(vecs[i].data);
            send_frame(vecs[i].data, vecs[i].stop, vecs[i].bit_t);
            tick(48);
            check($sformatf("vec%0d_ferr", i), 32'(ferr_cyc - f0), 32'(vecs[i].exp_ferr));
            check($sformatf("vec%0d_ovr", i), 32'(ovr_cyc - o0), 32'd0);
            check($sformatf("vec%0d_empty", i), 32'(u_if.fifo_empty_o), 32'(!vecs[i].exp_push));
            if (vecs[i].exp_push) begin
                pop_check($sformatf("vec%0d_pop", i));
                check($sformatf("vec%0d_drained", i), 32'(u_if.fifo_empty_o), 32'd1);
            end
        end

        // Fill to full back-to-back, ninth byte overruns
        f0 = ferr_cyc; o0 = ovr_cyc;
        for (int i = 0; i < 9; i++) begin
            if (i < 8) exp_q.push_back(8'(i));
            send_frame(8'(i), 1'b1, BIT_T);
            check($sformatf("fill%0d_full", i), 32'(u_if.fifo_full_o), 32'(i >= 7));
        end
        tick(20);
        check("ovr_pulse", 32'(ovr_cyc - o0), 32'd1);
        check("ovr_ferr", 32'(ferr_cyc - f0), 32'd0);
        for (int i = 0; i < 8; i++) pop_check($sformatf("ovr_pop%0d", i));
        check("ovr_empty", 32'(u_if.fifo_empty_o), 32'd1);
        check("ovr_notfull", 32'(u_if.fifo_full_o), 32'd0);

        // Full FIFO with a pop on the exact push cycle: no overrun, stays full
        for (int i = 0; i < 8; i++) begin
            exp_q.push_back(8'(8'h10 + i));
            send_frame(8'(8'h10 + i), 1'b1, BIT_T);
        end
        check("simul_full_pre", 32'(u_if.fifo_full_o), 32'd1);
        o0 = ovr_cyc;
        exp_q.push_back(8'h18);
        fork
            send_frame(8'h18, 1'b1, BIT_T);
            begin
                tick(154);
                pop_check("simul_pop");
                check("simul_full_post", 32'(u_if.fifo_full_o), 32'd1);
            end
        join
        tick(20);
        check("simul_ovr", 32'(ovr_cyc - o0), 32'd0);
        for (int i = 0; i < 8; i++) pop_check($sformatf("simul_drain%0d", i));
        check("simul_empty", 32'(u_if.fifo_empty_o), 32'd1);

        // Reset during data bit 3 discards the partial byte and FIFO contents
        exp_q.push_back(8'h42);
        send_frame(8'h42, 1'b1, BIT_T);
        tick(20);
        check("prerst_empty", 32'(u_if.fifo_empty_o), 32'd0);
        f0 = ferr_cyc; o0 = ovr_cyc;
        u_if.rx_i = 1'b0;
        #(BIT_T);
        for (int i = 0; i < 3; i++) begin
            u_if.rx_i = (i == 1);
            #(BIT_T);
        end
        u_if.rx_i = 1'b0;
        #(BIT_T / 2);
        rst = 1'b1;
        exp_q.delete();
        tick(1);
        check("midrst_empty", 32'(u_if.fifo_empty_o), 32'd1);
        check("midrst_full", 32'(u_if.fifo_full_o), 32'd0);
        check("midrst_ferr", 32'(u_if.frame_error_o), 32'd0);
        check("midrst_ovr", 32'(u_if.overrun_o), 32'd0);
        u_if.rx_i = 1'b1;
        tick(2);
        rst = 1'b0;
        tick(40);
        check("postrst_empty", 32'(u_if.fifo_empty_o), 32'd1);
        exp_q.push_back(8'h5A);
        send_frame(8'h5A, 1'b1, BIT_T);
        tick(40);
        pop_check("postrst_pop");
        check("postrst_drained", 32'(u_if.fifo_empty_o), 32'd1);
        check("postrst_ferr", 32'(ferr_cyc - f0), 32'd0);
        check("postrst_ovr", 32'(ovr_cyc - o0), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
